// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_next_unit.sv
// Next-PC select: hold, sequential +4, or word-aligned redirect target.
// Purely combinational; redirect takes priority over advance.
module pc_next_unit
    import fetch_stage_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_target & ~32'h0000_0003;
        end else if (advance) begin
            pc_next = pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, output slot feeding IF/ID.
// Accept at N, rvalid at N+k, valid_f at N+k+1; requests held off while IF/ID stalls a full slot.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_d,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_f,
    output logic [XLEN-1:0] Address_f,
    output logic [XLEN-1:0] PC4_f,
    output logic            valid_f
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] pc_next;
    logic            slot_free;
    logic            accept;
    logic            load;

    // A request is only issued when its response is guaranteed an empty slot.
    assign slot_free = !valid_f || !stall_d;
    assign imem_req  = (state == S_REQ) && slot_free && !redirect && !reset;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    assign load      = (state == S_WAIT) && imem_rvalid && !redirect;

    pc_next_unit u_pc_next (
        .pc              (pc),
        .advance         (accept),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc_next         (pc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            state  <= S_REQ;
        end else begin
            pc <= pc_next;
            if (accept) begin
                req_pc <= pc;
            end
            case (state)
                S_REQ: begin
                    if (accept) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state <= S_REQ;
                    end else if (redirect) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    // Once the stale response lands nothing is outstanding, even if redirected again.
                    if (imem_rvalid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_f   <= 1'b0;
            instr_f   <= NOP_INSTR;
            Address_f <= '0;
            PC4_f     <= '0;
        end else if (redirect) begin
            valid_f <= 1'b0;
            instr_f <= NOP_INSTR;
        end else if (load) begin
            valid_f   <= 1'b1;
            instr_f   <= imem_rdata;
            Address_f <= req_pc;
            PC4_f     <= req_pc + 32'd4;
        end else if (valid_f && !stall_d) begin
            valid_f <= 1'b0;
            instr_f <= NOP_INSTR;
        end
    end

    a_req_only_in_s_req: assert property (@(posedge clk) disable iff (reset)
        imem_req |-> (state == S_REQ));

    a_no_load_over_stalled: assert property (@(posedge clk) disable iff (reset)
        !(load && valid_f && stall_d));

    a_no_rvalid_in_s_req: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (state == S_REQ)));

endmodule
